// File: rtl/fp_pkg.sv
// Shared floating-point field widths, operand classes and a classify helper.
// Latency: none (declarations and combinational helper only).
// Backpressure: not applicable.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    // All-ones exponent: reserved for infinity and NaN.
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Classify a default-width operand; zero and denormal share FP_ZERO.
    function automatic fp_class_t fp_classify(input logic [EXP_W-1:0] exp,
                                              input logic [MAN_W-1:0] man);
        fp_class_t cls;
        if (exp == '0) begin
            cls = FP_ZERO;
        end else if (exp == EXP_MAX) begin
            cls = (man == '0) ? FP_INF : FP_NAN;
        end else begin
            cls = FP_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_classify_exp.sv
// First-stage decode: operand class plus the shifted exponent, two bits wider.
// Latency: combinational, registered by the parent into S1.
// Backpressure: none here; the parent gates capture with its stage enable.
module fp_classify_exp #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int SH_W  = 4
) (
    input  logic [EXP_W-1:0]        i_exp,
    input  logic [MAN_W-1:0]        i_man,
    input  logic [SH_W-1:0]         i_shift,
    output fp_pkg::fp_class_t       o_cls,
    output logic signed [EXP_W+1:0] o_e_new
);
    import fp_pkg::*;

    localparam int EW = EXP_W + 2;

    logic signed [EW-1:0] w_shift_ext;
    logic signed [EW-1:0] w_exp_ext;

    // Keep two guard bits so overflow and negative exponents survive to the compare.
    assign w_shift_ext = EW'($signed(i_shift));
    assign w_exp_ext   = $signed({2'b00, i_exp});
    assign o_e_new     = w_exp_ext + w_shift_ext;

    // Width-generic classification; denormals fold into the zero class.
    always_comb begin
        o_cls = FP_NORM;
        if (i_exp == '0) begin
            o_cls = FP_ZERO;
        end else if (&i_exp) begin
            o_cls = (i_man == '0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/fp_pow2_scale_pipe.sv
// Scales an IEEE-style operand by +/-2^shift with flush-to-zero and saturation.
// Latency: 2 cycles accepted-input to out_valid; 1 result per cycle.
// Backpressure: one global enable stalls both stages; in_ready = ~out_valid | out_ready.
module fp_pow2_scale_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    parameter  int SH_W  = 4,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [SH_W-1:0] shift,
    input  logic            negate,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    y,
    output logic            y_uf,
    output logic            y_of,
    input  logic            flag_clr,
    output logic            sticky_uf,
    output logic            sticky_of,
    output logic            sticky_nan
);
    import fp_pkg::*;

    localparam logic signed [EXP_W+1:0] E_ZERO = '0;
    localparam logic signed [EXP_W+1:0] E_TOP  = {2'b00, {EXP_W{1'b1}}};

    logic                    w_en;
    fp_class_t               w_cls;
    logic signed [EXP_W+1:0] w_e_new;
    logic [W-1:0]            w_y;
    logic                    w_uf;
    logic                    w_of;
    logic                    w_nan;

    logic                    r_s1_vld;
    logic [W-1:0]            r_s1_a;
    logic                    r_s1_s;
    fp_class_t               r_s1_cls;
    logic signed [EXP_W+1:0] r_s1_e_new;

    logic                    r_s2_vld;
    logic [W-1:0]            r_y;
    logic                    r_uf;
    logic                    r_of;
    logic                    r_nan;

    logic                    r_sticky_uf;
    logic                    r_sticky_of;
    logic                    r_sticky_nan;

    assign w_en      = ~r_s2_vld | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_s2_vld;
    assign y         = r_y;
    assign y_uf      = r_uf;
    assign y_of      = r_of;
    assign sticky_uf  = r_sticky_uf;
    assign sticky_of  = r_sticky_of;
    assign sticky_nan = r_sticky_nan;

    fp_classify_exp #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .SH_W  (SH_W)
    ) u_decode (
        .i_exp   (a[W-2:MAN_W]),
        .i_man   (a[MAN_W-1:0]),
        .i_shift (shift),
        .o_cls   (w_cls),
        .o_e_new (w_e_new)
    );

    // S2 result selection from the decoded S1 operand.
    always_comb begin
        w_y   = r_s1_a;
        w_uf  = 1'b0;
        w_of  = 1'b0;
        w_nan = 1'b0;
        case (r_s1_cls)
            FP_NAN: begin
                // NaN passes through untouched, sign and payload included.
                w_nan = 1'b1;
            end
            FP_INF: begin
                w_y = {r_s1_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            FP_ZERO: begin
                // Denormal inputs are flushed silently, not reported as underflow.
                w_y = {r_s1_s, {(EXP_W + MAN_W){1'b0}}};
            end
            default: begin
                if (r_s1_e_new <= E_ZERO) begin
                    w_y  = {r_s1_s, {(EXP_W + MAN_W){1'b0}}};
                    w_uf = 1'b1;
                end else if (r_s1_e_new >= E_TOP) begin
                    w_y  = {r_s1_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    w_of = 1'b1;
                end else begin
                    w_y = {r_s1_s, r_s1_e_new[EXP_W-1:0], r_s1_a[MAN_W-1:0]};
                end
            end
        endcase
    end

    // Two-stage pipeline; both stages advance together only when the output can drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_s     <= 1'b0;
            r_s1_cls   <= FP_ZERO;
            r_s1_e_new <= '0;
            r_s2_vld   <= 1'b0;
            r_y        <= '0;
            r_uf       <= 1'b0;
            r_of       <= 1'b0;
            r_nan      <= 1'b0;
        end else if (w_en) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_a     <= a;
                r_s1_s     <= a[W-1] ^ negate;
                r_s1_cls   <= w_cls;
                r_s1_e_new <= w_e_new;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_y   <= w_y;
                r_uf  <= w_uf;
                r_of  <= w_of;
                r_nan <= w_nan;
            end
        end
    end

    // Sticky exception flags accumulate on output transfers; clear wins over set.
    always_ff @(posedge clk) begin
        if (rst || flag_clr) begin
            r_sticky_uf  <= 1'b0;
            r_sticky_of  <= 1'b0;
            r_sticky_nan <= 1'b0;
        end else if (r_s2_vld && out_ready) begin
            r_sticky_uf  <= r_sticky_uf  | r_uf;
            r_sticky_of  <= r_sticky_of  | r_of;
            r_sticky_nan <= r_sticky_nan | r_nan;
        end
    end

endmodule
